// File: rtl/fifo_buffer_w.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_buffer_w
//  Description : Parametrised synchronous word FIFO with first-word-fall-
//                through head, occupancy count, almost-full watermark and
//                sticky overflow/underflow flags. Push and pop may both be
//                accepted in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_buffer_w #(
  parameter  int DATA_WIDTH      = 8,
  parameter  int DEPTH           = 8,
  parameter  int ALMOST_FULL_LVL = DEPTH - 1,
  localparam int COUNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [COUNT_W-1:0]    count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  // Pointer width never drops below one bit, even for tiny depths.
  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  localparam logic [COUNT_W-1:0] c_full_cnt = COUNT_W'(DEPTH);
  localparam logic [COUNT_W-1:0] c_af_cnt   = COUNT_W'(ALMOST_FULL_LVL);
  localparam logic [PTR_W-1:0]   c_last_ptr = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]   c_one_ptr  = PTR_W'(1);
  localparam logic [COUNT_W-1:0] c_one_cnt  = COUNT_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [COUNT_W-1:0]    r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;

  // Status flags decode the occupancy register only, so they are glitch-free.
  assign w_full      = (r_count == c_full_cnt);
  assign w_empty     = (r_count == '0);
  assign almost_full = (r_count >= c_af_cnt);
  assign fifo_full   = w_full;
  assign fifo_empty  = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle. clear suppresses both requests.
  assign w_push_ok = push && (!w_full || pop) && !clear;
  assign w_pop_ok  = pop && !w_empty && !clear;

  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_ptr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : (r_wr_ptr + c_one_ptr);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_last_ptr) ? '0 : (r_rd_ptr + c_one_ptr);

  // Head word falls through from storage; zero while nothing is buffered.
  assign o_data = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_one_cnt;
        2'b01:   r_count <= r_count - c_one_cnt;
        default: r_count <= r_count;
      endcase
      if (push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      if (pop && !w_pop_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
